seq_detect_param: RTL
=====================

# seq_detect_param

Parametrised serial bit-pattern detector: the next generation of the fixed two-bit-state Mealy sequence detector. It watches a 1-bit serial input and flags every occurrence of a compile-time pattern of configurable length. Overlapping or non-overlapping matching is selected at run time, and both a combinational Mealy flag and a registered Moore flag are produced. Matches are tallied in a saturating counter, and the current prefix-match progress is exported on `stat` for lab observation.

## Interface
- `N`, default 4: pattern length in bits, 2..16.
- `PATTERN`, default 4'b1101, width N: target sequence. `PATTERN[N-1]` is the first bit received.
- `CNT_W`, default 8: width of the match counter, ≥ 2.
- `SW` (localparam) = clog2(N).
- `clk` input, 1 bit: single clock, rising edge.
- `clr` input, 1 bit: reset, **asynchronous, active-high**.
- `en` input, 1 bit: `din` is accepted on a rising edge only when `en`=1.
- `din` input, 1 bit: serial data.
- `overlap` input, 1 bit: 1 = overlapping matches allowed; 0 = bits of a reported match cannot start a new one.
- `count_clr` input, 1 bit: synchronous clear of `mcount`/`mcount_sat`.
- `dout` output, 1 bit: Mealy match flag, combinational.
- `dout_q` output, 1 bit: registered match flag (Moore view).
- `stat` output, SW bits: current prefix-match state k, 0..N-1.
- `mcount` output, CNT_W bits: number of matches, saturating.
- `mcount_sat` output, 1 bit: high once `mcount` has reached all-ones.

## Operation
- State k is the length of the longest prefix of PATTERN equal to the suffix of the accepted bits since the last reset or consumption, with k < N.
- Next state computation, per accepted bit b:
  - Form candidate string s = (last k bits) followed by b.
  - If k+1 = N and s = PATTERN, this is a **match**.
  - Otherwise the next k is the longest j ≤ min(k+1, N-1) such that the last j bits of s equal `PATTERN[N-1 -: j]`.
- On a match:
  - `overlap`=1: next k = longest proper border of PATTERN. For 1101 this is 1.
  - `overlap`=0: next k = 0.
- The next-state function is combinational over the k-bit history. Use an internal history shift register of N-1 bits plus k; borders are computed at elaboration or by a generate-loop compare. No runtime tables.
- `dout` = match condition AND `en` AND NOT `clr`. It is purely combinational from `din`, `en` and the registered state.
- `dout_q` <= `dout` on each edge; it is cleared on a non-accepting edge (`en`=0).
- Counter, on each edge:
  - `count_clr`=1 and match: `mcount` <= 1.
  - `count_clr`=1, no match: `mcount` <= 0.
  - Match only: `mcount` <= `mcount`+1, holding at 2^CNT_W − 1.
  - `mcount_sat` = (`mcount` == all-ones), registered alongside `mcount`.
- `en`=0: no state change, `dout`=0, counter is affected by `count_clr` only.
- `overlap` is sampled on the same edge that consumes the matching bit. Changing it mid-stream affects only subsequent match consumptions.

## Timing
- `clr`=1 forces, immediately and asynchronously: k=0, history=0, `dout_q`=0, `mcount`=0, `mcount_sat`=0, and `dout`=0.
- The first edge after `clr` falls accepts a bit normally.
- `dout` rises in the same cycle the final pattern bit is presented, before the capturing edge.
- `dout_q` rises one cycle later and lasts one cycle per match.
- `stat` and `mcount` update on the edge that accepts the bit; latency is 1 cycle.
- Back-to-back matches (overlap=1, pattern period < N) give consecutive `dout` pulses with no gap.
- If `clr` is asserted mid-pattern, the partial prefix is discarded. A pattern must be fully re-received after release.
- Throughput: one bit per clock.

## Test plan
All scenarios use N=4, PATTERN=1101 unless stated otherwise.

- **Reset:** hold `clr`=1 for 50 ns while `din` toggles -> `dout`, `dout_q`, `stat`, `mcount` and `mcount_sat` all stay 0. After release, `din`=1,1 -> `stat` = 1 then 2.
- **Overlap on:** `overlap`=1, stream 1101101 -> `dout` high on bits 4 and 7; `stat` after each bit = 1,2,3,1,2,3,1; `mcount`=2.
- **Overlap off:** `overlap`=0, stream 1101101 -> match on bit 4 only, `stat` = 0 after bit 4, `mcount`=1. Stream 11011101 -> matches on bits 4 and 8.
- **Enable gaps:** stream 1,1,0,1 with `en`=0 cycles inserted between each bit (`din` random in those cycles) -> exactly one match; `dout`=0 during every `en`=0 cycle; `stat` holds during gaps.
- **Counter saturation:** CNT_W=2, five matches -> `mcount` goes 1,2,3,3,3 and `mcount_sat`=1 from the third match. Then `count_clr`=1 in the same cycle as a match -> `mcount`=1, `mcount_sat`=0.
- **Async reset mid-pattern:** send 110, pulse `clr` high for 10 ns between clock edges -> `stat` drops to 0 immediately. Then `din`=1 -> no match, `stat`=1.

Source files
------------

// File: rtl/seq_detect_param.sv
// seq_detect_param
// ----------------
// Serial bit-pattern detector for a compile-time PATTERN of N bits.
// PATTERN[N-1] is the first bit received. Every occurrence of the
// pattern in the accepted bit stream is flagged. Matches may overlap,
// or they may be consumed, under control of the run-time `overlap` input.
//
// Ports
//   clk        : rising-edge clock
//   clr        : asynchronous active-high reset of all state
//   en         : din is accepted on a rising edge only when en=1
//   din        : serial data bit
//   overlap    : 1 = a match restarts from the longest border of PATTERN,
//                0 = a match restarts from the empty prefix
//   count_clr  : synchronous clear of mcount / mcount_sat
//   dout       : Mealy match flag (combinational; asserted while the final
//                pattern bit is presented)
//   dout_q     : dout registered one cycle later
//   stat       : current prefix-match length k, 0..N-1
//   mcount     : saturating match counter
//   mcount_sat : high while mcount is all-ones
module seq_detect_param #(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1101,
  parameter int             CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    din,
  input  logic                    overlap,
  input  logic                    count_clr,
  output logic                    dout,
  output logic                    dout_q,
  output logic [$clog2(N)-1:0]    stat,
  output logic [CNT_W-1:0]        mcount,
  output logic                    mcount_sat
);

  localparam int SW = $clog2(N);

  // Length of the longest proper border of PATTERN: the largest j < N whose
  // first-received j bits equal its last-received j bits.
  function automatic int calc_border();
    int   best;
    logic ok;
    best = 0;
    for (int j = 1; j < N; j++) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++) begin
        if (PATTERN[i] != PATTERN[N-j+i]) begin
          ok = 1'b0;
        end else begin
          ok = ok;
        end
      end
      if (ok) begin
        best = j;
      end else begin
        best = best;
      end
    end
    return best;
  endfunction

  localparam int            BORDER   = calc_border();
  localparam logic [SW-1:0] BORDER_K = SW'(BORDER);
  localparam logic [SW-1:0] K_LAST   = SW'(N - 1);
  localparam logic [SW-1:0] K_ZERO   = {SW{1'b0}};

  logic [SW-1:0]    k_q, k_d;
  logic [N-2:0]     hist_q, hist_d;
  logic [N-1:0]     win_s;
  logic             match_s;
  logic             match_acc_s;
  logic             ok_s;
  logic [SW-1:0]    adv_k_s;
  logic [CNT_W-1:0] mcount_q, mcount_d;
  logic             mcount_sat_q, mcount_sat_d;
  logic             dout_q_d;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Candidate window and prefix search: win_s[0] is the bit being presented,
  // win_s[j-1:0] are the last j bits of the candidate string. A prefix of
  // length j only counts while j <= k+1, so bits older than the current
  // partial match (e.g. bits of a consumed match) never extend a prefix.
  always_comb begin
    win_s   = {hist_q, din};
    match_s = (k_q == K_LAST) && (win_s == PATTERN);
    adv_k_s = K_ZERO;
    ok_s    = 1'b0;
    for (int j = 1; j < N; j++) begin
      ok_s = 1'b1;
      for (int i = 0; i < j; i++) begin
        if (win_s[i] != PATTERN[N-j+i]) begin
          ok_s = 1'b0;
        end else begin
          ok_s = ok_s;
        end
      end
      if (ok_s && (j <= int'(k_q) + 1)) begin
        adv_k_s = SW'(j);
      end else begin
        adv_k_s = adv_k_s;
      end
    end
  end

  // State register: prefix length and bit history.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      k_q    <= K_ZERO;
      hist_q <= {(N-1){1'b0}};
    end else begin
      k_q    <= k_d;
      hist_q <= hist_d;
    end
  end

  // Next-state logic: advance on an accepted bit, restart after a match.
  always_comb begin
    k_d    = k_q;
    hist_d = hist_q;
    if (en) begin
      hist_d = win_s[N-2:0];
      if (match_s) begin
        if (overlap) begin
          k_d = BORDER_K;
        end else begin
          k_d = K_ZERO;
        end
      end else begin
        k_d = adv_k_s;
      end
    end else begin
      k_d    = k_q;
      hist_d = hist_q;
    end
  end

  // Output logic: Mealy flag, masked by enable and by reset.
  always_comb begin
    dout        = match_s & en & ~clr;
    match_acc_s = match_s & en;
    stat        = k_q;
  end

  // Match counter next value: count_clr wins but still counts a coincident match.
  always_comb begin
    mcount_d = mcount_q;
    if (count_clr) begin
      if (match_acc_s) begin
        mcount_d = CNT_ONE;
      end else begin
        mcount_d = CNT_ZERO;
      end
    end else if (match_acc_s && !(&mcount_q)) begin
      mcount_d = mcount_q + CNT_ONE;
    end else begin
      mcount_d = mcount_q;
    end
    mcount_sat_d = &mcount_d;
    dout_q_d     = dout;
  end

  // Registered outputs: delayed match flag and counter with its saturation flag.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      dout_q       <= 1'b0;
      mcount_q     <= CNT_ZERO;
      mcount_sat_q <= 1'b0;
    end else begin
      dout_q       <= dout_q_d;
      mcount_q     <= mcount_d;
      mcount_sat_q <= mcount_sat_d;
    end
  end

  assign mcount     = mcount_q;
  assign mcount_sat = mcount_sat_q;

endmodule
